// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline run/stall/flush controller:
// controller state encodings, syscall service codes and the default counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_STEP  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [31:0] SYSCALL_PAUSE = 32'h0000_0032;
  localparam logic [31:0] SYSCALL_HALT  = 32'h0000_000A;

  localparam int unsigned CNT_W_DEF = 32;

  // Pipeline buffers may only move in RUN or STEP.
  function automatic logic is_go(input state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

  // Classifies a WB syscall argument: bit0 = pause request, bit1 = halt request.
  function automatic logic [1:0] syscall_kind(input logic [31:0] a0);
    return {a0 == SYSCALL_HALT, a0 == SYSCALL_PAUSE};
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stat_counter.sv
// Single statistic counter: increments on inc, wraps or saturates at all-ones,
// clears asynchronously on rst.
module stat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic at_max;

  assign at_max = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      if (SATURATE && at_max) begin
        cnt <= CNT_MAX;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central run/stall/flush controller for the MIPS pipeline: decides each cycle whether the
// PC and each inter-stage buffer advance, hold or clear; adds single-step, syscall pause/halt and stats.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned NSTAGES     = 5,
  parameter int unsigned STALL_STAGE = 1,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter bit          SATURATE    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cont_in,
  input  logic               step_mode,
  input  logic               bubble,
  input  logic               redirect,
  input  logic               syscall_pause,
  input  logic               syscall_halt,
  output logic               pc_en,
  output logic [NSTAGES-2:0] buf_en,
  output logic [NSTAGES-2:0] buf_clr,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int unsigned NBUF = NSTAGES - 1;

  // Buffers below the stall point hold; the stall buffer itself takes the bubble.
  localparam logic [NBUF-1:0] STALL_HOLD = NBUF'((1 << STALL_STAGE) - 1);
  localparam logic [NBUF-1:0] STALL_CLR  = NBUF'(1 << STALL_STAGE);
  localparam logic [NBUF-1:0] FLUSH_CLR  = NBUF'((1 << FLUSH_DEPTH) - 1);

  state_t state_q;
  state_t state_d;
  logic   cont_s1;
  logic   cont_s2;
  logic   cont_d;
  logic   cont_rise;
  logic   mask;
  logic   go;
  logic   stall_inc;
  logic   flush_inc;

  assign cont_rise = cont_s2 & ~cont_d;
  assign go        = is_go(state_q);
  assign stall_inc = go & bubble & ~redirect;
  assign flush_inc = go & redirect;
  assign state     = state_q;

  // Continue button: two-flop synchroniser plus edge-detect delay flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont_s1 <= 1'b0;
      cont_s2 <= 1'b0;
      cont_d  <= 1'b0;
    end else begin
      cont_s1 <= cont_in;
      cont_s2 <= cont_s1;
      cont_d  <= cont_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (syscall_halt) begin
          state_d = ST_HALT;
        end else if (syscall_pause && !mask) begin
          state_d = ST_PAUSE;
        end else if (step_mode) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (cont_rise) begin
          state_d = step_mode ? ST_STEP : ST_RUN;
        end
      end
      ST_STEP: begin
        state_d = syscall_halt ? ST_HALT : ST_PAUSE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // The syscall that caused the pause is still in WB on resume; ignore it for one go cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= 1'b0;
    end else if ((state_q == ST_PAUSE) && (state_d != ST_PAUSE)) begin
      mask <= 1'b1;
    end else if (go) begin
      mask <= 1'b0;
    end
  end

  // Buffer/PC gating; redirect flush takes priority over the load-use bubble.
  always_comb begin
    pc_en   = 1'b0;
    buf_en  = '0;
    buf_clr = '0;
    if (rst) begin
      buf_clr = '1;
    end else if (go) begin
      pc_en  = 1'b1;
      buf_en = '1;
      if (redirect) begin
        buf_clr = FLUSH_CLR;
      end else if (bubble) begin
        pc_en   = 1'b0;
        buf_en  = ~STALL_HOLD;
        buf_clr = STALL_CLR;
      end
    end
  end

  stat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .inc (go),
    .cnt (cycle_cnt)
  );

  stat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  stat_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes per-cycle expectations, a negedge
// monitor pops and compares; two 4-bit instances cover counter wrap and saturation.
module tb_pipeline_ctrl;
  import pipe_pkg::*;

  logic clk           = 1'b0;
  logic rst           = 1'b1;
  logic rst_small     = 1'b1;
  logic cont_in       = 1'b0;
  logic step_mode     = 1'b0;
  logic bubble        = 1'b0;
  logic redirect      = 1'b0;
  logic syscall_pause = 1'b0;
  logic syscall_halt  = 1'b0;

  logic        pc_en;
  logic [3:0]  buf_en;
  logic [3:0]  buf_clr;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic       w_pc_en, s_pc_en;
  logic [3:0] w_buf_en, s_buf_en, w_buf_clr, s_buf_clr;
  logic [1:0] w_state, s_state;
  logic [3:0] w_cycle, w_stall, w_flush, s_cycle, s_stall, s_flush;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .cont_in(cont_in), .step_mode(step_mode), .bubble(bubble),
    .redirect(redirect), .syscall_pause(syscall_pause), .syscall_halt(syscall_halt),
    .pc_en(pc_en), .buf_en(buf_en), .buf_clr(buf_clr), .state(state),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.CNT_W(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst_small), .cont_in(cont_in), .step_mode(step_mode), .bubble(bubble),
    .redirect(redirect), .syscall_pause(syscall_pause), .syscall_halt(syscall_halt),
    .pc_en(w_pc_en), .buf_en(w_buf_en), .buf_clr(w_buf_clr), .state(w_state),
    .cycle_cnt(w_cycle), .stall_cnt(w_stall), .flush_cnt(w_flush)
  );

  pipeline_ctrl #(.CNT_W(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst_small), .cont_in(cont_in), .step_mode(step_mode), .bubble(bubble),
    .redirect(redirect), .syscall_pause(syscall_pause), .syscall_halt(syscall_halt),
    .pc_en(s_pc_en), .buf_en(s_buf_en), .buf_clr(s_buf_clr), .state(s_state),
    .cycle_cnt(s_cycle), .stall_cnt(s_stall), .flush_cnt(s_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          kind;
    logic [1:0]  st;
    logic        pc;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic [31:0] cc;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [3:0]  wc;
    logic [3:0]  satc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [31:0] e_cc = 0;
  logic [31:0] e_sc = 0;
  logic [31:0] e_fc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares whatever expectation is tagged for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].tag == cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.kind == 0) begin
        if ({state, pc_en, buf_en, buf_clr, cycle_cnt, stall_cnt, flush_cnt} ===
            {e.st, e.pc, e.en, e.clr, e.cc, e.sc, e.fc}) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got st=%0d pc=%b en=%b clr=%b cc=%0d sc=%0d fc=%0d, want st=%0d pc=%b en=%b clr=%b cc=%0d sc=%0d fc=%0d",
                   e.nm, state, pc_en, buf_en, buf_clr, cycle_cnt, stall_cnt, flush_cnt,
                   e.st, e.pc, e.en, e.clr, e.cc, e.sc, e.fc);
        end
      end else begin
        if ({w_cycle, s_cycle} === {e.wc, e.satc}) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got wrap_cnt=%0d sat_cnt=%0d, want wrap_cnt=%0d sat_cnt=%0d",
                   e.nm, w_cycle, s_cycle, e.wc, e.satc);
        end
      end
    end
  end

  // One cycle of stimulus with the hand-traced expected state for that cycle.
  task automatic tick(input logic [1:0] est, input logic bub, input logic red, input logic sp,
                      input logic sh, input logic cont, input logic sm, input string nm);
    exp_t e;
    logic go;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bubble = bub; redirect = red; syscall_pause = sp; syscall_halt = sh;
    cont_in = cont; step_mode = sm;
    go = (est == ST_RUN) || (est == ST_STEP);
    e.tag = cyc; e.kind = 0; e.st = est; e.nm = nm;
    e.cc = e_cc; e.sc = e_sc; e.fc = e_fc; e.wc = 4'd0; e.satc = 4'd0;
    if (!go) begin
      e.pc = 1'b0; e.en = 4'b0000; e.clr = 4'b0000;
    end else if (red) begin
      e.pc = 1'b1; e.en = 4'b1111; e.clr = 4'b0011;
    end else if (bub) begin
      e.pc = 1'b0; e.en = 4'b1110; e.clr = 4'b0010;
    end else begin
      e.pc = 1'b1; e.en = 4'b1111; e.clr = 4'b0000;
    end
    sb.push_back(e);
    if (go) begin
      e_cc++;
      if (bub && !red) e_sc++;
      if (red) e_fc++;
    end
  endtask

  task automatic rst_chk(input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bubble = 0; redirect = 0; syscall_pause = 0; syscall_halt = 0; cont_in = 0; step_mode = 0;
    e_cc = 0; e_sc = 0; e_fc = 0;
    e.tag = cyc; e.kind = 0; e.st = ST_RUN; e.pc = 1'b0; e.en = 4'b0000; e.clr = 4'b1111;
    e.cc = 0; e.sc = 0; e.fc = 0; e.wc = 4'd0; e.satc = 4'd0; e.nm = nm;
    sb.push_back(e);
  endtask

  // Three cycles from cont_in going high to the edge that leaves PAUSE.
  task automatic cont_pulse(input logic [1:0] est, input logic sp, input logic sm, input string nm);
    tick(est, 0, 0, sp, 0, 1, sm, nm);
    tick(est, 0, 0, sp, 0, 0, sm, nm);
    tick(est, 0, 0, sp, 0, 0, sm, nm);
  endtask

  task automatic tick_small(input logic chk, input logic [3:0] ew, input logic [3:0] es, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_small = 1'b0;
    if (chk) begin
      e.tag = cyc; e.kind = 1; e.st = 2'd0; e.pc = 1'b0; e.en = 4'd0; e.clr = 4'd0;
      e.cc = 0; e.sc = 0; e.fc = 0; e.wc = ew; e.satc = es; e.nm = nm;
      sb.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_chk("reset");
    rst_chk("reset_hold");
    // Idle run: the 11th check sees ten counted cycles.
    for (int i = 0; i < 10; i++) tick(ST_RUN, 0, 0, 0, 0, 0, 0, "idle");
    tick(ST_RUN, 0, 0, 0, 0, 0, 0, "idle_cc10");
    tick(ST_RUN, 1, 0, 0, 0, 0, 0, "stall");
    tick(ST_RUN, 0, 0, 0, 0, 0, 0, "stall_cnt");
    tick(ST_RUN, 1, 1, 0, 0, 0, 0, "flush_beats_stall");
    tick(ST_RUN, 0, 0, 0, 0, 0, 0, "flush_cnt");
    // Syscall pause, resume with the syscall still resident.
    tick(ST_RUN, 0, 0, 1, 0, 0, 0, "pause_req");
    tick(ST_PAUSE, 0, 0, 1, 0, 0, 0, "paused");
    cont_pulse(ST_PAUSE, 1, 0, "pause_wait");
    tick(ST_RUN, 0, 0, 1, 0, 0, 0, "masked_run");
    tick(ST_RUN, 0, 0, 0, 0, 0, 0, "run_after");
    // Single-step mode: three steps.
    tick(ST_RUN, 0, 0, 0, 0, 0, 1, "enter_step");
    for (int i = 0; i < 3; i++) begin
      cont_pulse(ST_PAUSE, 0, 1, "step_wait");
      tick(ST_STEP, 0, 0, 0, 0, 0, 1, "step");
    end
    cont_pulse(ST_PAUSE, 0, 0, "leave_step");
    tick(ST_RUN, 0, 0, 0, 0, 0, 0, "resume");
    // Halt absorbs continue and gates everything.
    tick(ST_RUN, 0, 0, 0, 1, 0, 0, "halt_req");
    tick(ST_HALT, 0, 0, 0, 0, 0, 0, "halted");
    cont_pulse(ST_HALT, 0, 0, "halt_cont");
    tick(ST_HALT, 0, 0, 0, 0, 0, 0, "halt_stays");
    tick(ST_HALT, 1, 1, 0, 0, 0, 0, "halt_gated");
    rst_chk("mid_reset");
    tick(ST_RUN, 0, 0, 0, 0, 0, 0, "post_reset");
    tick(ST_RUN, 0, 0, 0, 0, 0, 0, "post_reset_cnt");
    // 4-bit counters: wrap vs saturate.
    tick_small(1, 4'd0, 4'd0, "small_start");
    for (int i = 1; i < 15; i++) tick_small(0, 4'd0, 4'd0, "");
    tick_small(1, 4'd15, 4'd15, "small_15");
    tick_small(1, 4'd0, 4'd15, "wrap_16");
    tick_small(1, 4'd1, 4'd15, "wrap_17");
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sb.size());
      n_chk += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
